// File: rtl/axum_ctx_mover_if.sv
// Data-bus bundle between the context mover (master) and the memory system (slave).
// Latency: none, wires only.
// Backpressure: the slave stalls requests by withholding data_gnt_i and paces responses with data_rvalid_i.
interface axum_ctx_mover_if #(
  parameter int unsigned AddressWidth = 32,
  parameter int unsigned DataWidth    = 32
) ();
  logic                      data_req_o;
  logic                      data_gnt_i;
  logic [AddressWidth-1:0]   data_addr_o;
  logic                      data_we_o;
  logic [DataWidth/8-1:0]    data_be_o;
  logic [DataWidth-1:0]      data_wdata_o;
  logic                      data_rvalid_i;
  logic [DataWidth-1:0]      data_rdata_i;
  logic                      data_err_i;

  modport master (
    output data_req_o, data_addr_o, data_we_o, data_be_o, data_wdata_o,
    input  data_gnt_i, data_rvalid_i, data_rdata_i, data_err_i
  );

  modport slave (
    input  data_req_o, data_addr_o, data_we_o, data_be_o, data_wdata_o,
    output data_gnt_i, data_rvalid_i, data_rdata_i, data_err_i
  );
endinterface

// File: rtl/axum_ctx_mover.sv
// Copies registers x1..x31 of one register context between the regfile map window and a memory save area.
// Latency: 4 cycles per register on a zero-wait bus, done_o 125 cycles after start_i.
// Backpressure: request fields held until data_gnt_i, one outstanding transaction; interrupt built only with AXUM_CTX_MOVER_IRQ_EN.
module axum_ctx_mover #(
  parameter int unsigned AddressWidth = 32,
  parameter int unsigned DataWidth    = 32,
  parameter logic [31:0] RfBase       = 32'h0002_0000
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    start_i,
  input  logic                    dir_i,
  input  logic [1:0]              ctx_i,
  input  logic [1:0]              active_ctx_i,
  input  logic [AddressWidth-1:0] mem_base_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    err_o,
  output logic                    intr_o,
  input  logic                    intr_clr_i,
  axum_ctx_mover_if.master        bus
);

  localparam int unsigned BeWidth = DataWidth / 8;
  localparam logic [AddressWidth-1:0] RF_BASE = AddressWidth'(RfBase);

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, FIN} state_e;

  state_e                  state_q;
  logic                    dir_q;
  logic [1:0]              ctx_q;
  logic [AddressWidth-1:0] base_q;
  logic [4:0]              idx_q;
  logic [DataWidth-1:0]    hold_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    err_q;
  logic                    req_q;
  logic                    we_q;
  logic [BeWidth-1:0]      be_q;
  logic [AddressWidth-1:0] addr_q;

  logic [AddressWidth-1:0] base_in;
  logic                    enter_fin;
  logic [1:0]              unused_base_lsb;

  // Each context owns a 128-byte slice of the regfile window; word idx sits at idx*4.
  function automatic logic [AddressWidth-1:0] rf_addr(input logic [1:0] c, input logic [4:0] i);
    rf_addr = RF_BASE + AddressWidth'({c, 7'd0}) + AddressWidth'({i, 2'b00});
  endfunction

  function automatic logic [AddressWidth-1:0] mem_addr(input logic [AddressWidth-1:0] b,
                                                       input logic [4:0] i);
    mem_addr = b + AddressWidth'({i, 2'b00});
  endfunction

  // The save area is word aligned; the two low base bits are dropped.
  assign base_in         = {mem_base_i[AddressWidth-1:2], 2'b00};
  assign unused_base_lsb = mem_base_i[1:0];

  // Transitions that land in FIN: context clash at start, bus error, or last register written.
  always_comb begin
    enter_fin = 1'b0;
    case (state_q)
      IDLE:    enter_fin = start_i && (ctx_i == active_ctx_i);
      RD_WAIT: enter_fin = bus.data_rvalid_i && bus.data_err_i;
      WR_WAIT: enter_fin = bus.data_rvalid_i && (bus.data_err_i || (idx_q == 5'd31));
      default: enter_fin = 1'b0;
    endcase
  end

  // Transfer FSM; every bus output is a register updated on the transition that needs it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      dir_q   <= 1'b0;
      ctx_q   <= '0;
      base_q  <= '0;
      idx_q   <= '0;
      hold_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      be_q    <= '0;
      addr_q  <= '0;
    end else begin
      done_q <= enter_fin;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            dir_q  <= dir_i;
            ctx_q  <= ctx_i;
            base_q <= base_in;
            idx_q  <= 5'd1;
            busy_q <= 1'b1;
            if (ctx_i == active_ctx_i) begin
              // Moving the live context would corrupt it: fail without touching the bus.
              err_q   <= 1'b1;
              state_q <= FIN;
            end else begin
              err_q   <= 1'b0;
              req_q   <= 1'b1;
              we_q    <= 1'b0;
              addr_q  <= dir_i ? mem_addr(base_in, 5'd1) : rf_addr(ctx_i, 5'd1);
              state_q <= RD_REQ;
            end
          end
        end
        RD_REQ: begin
          if (bus.data_gnt_i) begin
            req_q   <= 1'b0;
            addr_q  <= '0;
            state_q <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (bus.data_rvalid_i) begin
            if (bus.data_err_i) begin
              err_q   <= 1'b1;
              state_q <= FIN;
            end else begin
              hold_q  <= bus.data_rdata_i;
              req_q   <= 1'b1;
              we_q    <= 1'b1;
              be_q    <= '1;
              addr_q  <= dir_q ? rf_addr(ctx_q, idx_q) : mem_addr(base_q, idx_q);
              state_q <= WR_REQ;
            end
          end
        end
        WR_REQ: begin
          if (bus.data_gnt_i) begin
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            be_q    <= '0;
            addr_q  <= '0;
            state_q <= WR_WAIT;
          end
        end
        WR_WAIT: begin
          if (bus.data_rvalid_i) begin
            if (bus.data_err_i) begin
              err_q   <= 1'b1;
              state_q <= FIN;
            end else if (idx_q == 5'd31) begin
              state_q <= FIN;
            end else begin
              idx_q   <= idx_q + 5'd1;
              req_q   <= 1'b1;
              addr_q  <= dir_q ? mem_addr(base_q, idx_q + 5'd1) : rf_addr(ctx_q, idx_q + 5'd1);
              state_q <= RD_REQ;
            end
          end
        end
        FIN: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o           = busy_q;
  assign done_o           = done_q;
  assign err_o            = err_q;
  assign bus.data_req_o   = req_q;
  assign bus.data_we_o    = we_q;
  assign bus.data_be_o    = be_q;
  assign bus.data_addr_o  = addr_q;
  // Write data is only presented while a write request is on the bus.
  assign bus.data_wdata_o = (req_q && we_q) ? hold_q : '0;

`ifdef AXUM_CTX_MOVER_IRQ_EN
  logic intr_q;
  logic intr_d;

  // Completion sets the interrupt; a clear in the same cycle loses to the set.
  always_comb begin
    intr_d = intr_q;
    if (intr_clr_i) intr_d = 1'b0;
    if (enter_fin)  intr_d = 1'b1;
  end

  // Interrupt flag register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) intr_q <= 1'b0;
    else         intr_q <= intr_d;
  end

  assign intr_o = intr_q;
`else
  logic unused_intr_clr;
  assign unused_intr_clr = intr_clr_i;
  assign intr_o          = 1'b0;
`endif

endmodule

// File: tb/tb_axum_ctx_mover.sv
// Bench for axum_ctx_mover: directed scenarios plus randomized transfers against an address/data model.
// Latency: checks done_o timing on a zero-wait bus.
// Backpressure: a bus responder with programmable grant and response delays and error injection.
module tb_axum_ctx_mover;
  localparam logic [31:0] RF = 32'h0002_0000;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        dir;
  logic [1:0]  ctx;
  logic [1:0]  act;
  logic [31:0] base;
  logic        intr_clr;
  logic        busy, done, err, intr;

  axum_ctx_mover_if #(.AddressWidth(32), .DataWidth(32)) bus ();

  axum_ctx_mover #(.AddressWidth(32), .DataWidth(32), .RfBase(RF)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .dir_i(dir), .ctx_i(ctx),
    .active_ctx_i(act), .mem_base_i(base), .busy_o(busy), .done_o(done), .err_o(err),
    .intr_o(intr), .intr_clr_i(intr_clr), .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Bus transaction log written by the responder only.
  logic [31:0] log_addr[$];
  logic        log_we[$];
  logic [31:0] log_wdata[$];
  logic [3:0]  log_be[$];
  logic [31:0] log_rsp[$];
  int          wr_rsp_total = 0;
  int          stab_checks  = 0;
  int          stab_viol    = 0;
  int          zero_viol    = 0;

  // Responder knobs written by the main sequence only.
  int gnt_delay  = 0;
  int rsp_delay  = 0;
  int err_wr_at  = -1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Slave side of the bus: grant after gnt_delay waiting cycles, respond rsp_delay cycles later.
  initial begin
    bit          rsp_pending;
    bit          rsp_is_wr;
    int          rsp_cnt;
    int          wait_cnt;
    logic [31:0] s_addr, s_wdata, rd;
    logic        s_we;
    logic [3:0]  s_be;
    rsp_pending = 0; rsp_is_wr = 0; rsp_cnt = 0; wait_cnt = 0;
    s_addr = 0; s_wdata = 0; s_we = 0; s_be = 0;
    bus.data_gnt_i = 0; bus.data_rvalid_i = 0; bus.data_rdata_i = 0; bus.data_err_i = 0;
    forever begin
      @(negedge clk);
      bus.data_gnt_i = 0; bus.data_rvalid_i = 0; bus.data_rdata_i = 0; bus.data_err_i = 0;
      if (!rst_n) begin
        if (rsp_pending) log_rsp.push_back(32'h0);
        rsp_pending = 0;
        wait_cnt    = 0;
      end else begin
        if (!bus.data_req_o && (bus.data_addr_o !== 32'h0 || bus.data_wdata_o !== 32'h0))
          zero_viol++;
        if (rsp_pending) begin
          if (rsp_cnt == 0) begin
            bus.data_rvalid_i = 1;
            rsp_pending = 0;
            if (rsp_is_wr) begin
              wr_rsp_total++;
              if (wr_rsp_total == err_wr_at) bus.data_err_i = 1;
              log_rsp.push_back(32'h0);
            end else begin
              rd = $urandom;
              bus.data_rdata_i = rd;
              log_rsp.push_back(rd);
            end
          end else begin
            rsp_cnt--;
          end
        end else if (bus.data_req_o) begin
          if (wait_cnt == 0) begin
            s_addr = bus.data_addr_o; s_we = bus.data_we_o;
            s_wdata = bus.data_wdata_o; s_be = bus.data_be_o;
          end else begin
            stab_checks++;
            if (s_addr !== bus.data_addr_o || s_we !== bus.data_we_o ||
                s_wdata !== bus.data_wdata_o || s_be !== bus.data_be_o)
              stab_viol++;
          end
          if (wait_cnt >= gnt_delay) begin
            bus.data_gnt_i = 1;
            log_addr.push_back(bus.data_addr_o);
            log_we.push_back(bus.data_we_o);
            log_wdata.push_back(bus.data_wdata_o);
            log_be.push_back(bus.data_be_o);
            rsp_pending = 1;
            rsp_is_wr   = bus.data_we_o;
            rsp_cnt     = rsp_delay;
            wait_cnt    = 0;
          end else begin
            wait_cnt++;
          end
        end
      end
    end
  end

  task automatic do_start(input logic d, input logic [1:0] c, input logic [1:0] a,
                          input logic [31:0] b);
    @(negedge clk);
    dir = d; ctx = c; act = a; base = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Returns the number of rising edges from the one that sampled start_i to the one raising done_o.
  task automatic wait_done(output int cyc, output bit busy_ok);
    cyc = 1;
    busy_ok = 1;
    while (!done && cyc < 4000) begin
      if (!busy) busy_ok = 0;
      @(negedge clk);
      cyc++;
    end
    chk("done_seen", done, 1);
  endtask

  // Reference: register i moves between RF + ctx*128 + 4i and (base & ~3) + 4i, read then write.
  task automatic check_xfer(input int b0, input logic d, input logic [1:0] c,
                            input logic [31:0] b, input int nreg);
    logic [31:0] rfa, mma, ra, wa;
    int k;
    chk("xfer_len", 64'(log_addr.size() - b0), 64'(2 * nreg));
    if (log_addr.size() - b0 == 2 * nreg && log_rsp.size() >= b0 + 2 * nreg) begin
      for (int i = 1; i <= nreg; i++) begin
        rfa = RF + 32'(c) * 32'd128 + 32'(i) * 32'd4;
        mma = (b & 32'hFFFF_FFFC) + 32'(i) * 32'd4;
        ra  = d ? mma : rfa;
        wa  = d ? rfa : mma;
        k   = b0 + 2 * (i - 1);
        chk("rd_addr", log_addr[k], ra);
        chk("rd_we", log_we[k], 0);
        chk("wr_addr", log_addr[k+1], wa);
        chk("wr_we", log_we[k+1], 1);
        chk("wr_be", log_be[k+1], 4'hF);
        chk("wr_data", log_wdata[k+1], log_rsp[k]);
      end
    end
  endtask

  // Completion pulse length and interrupt behaviour after done_o has been seen.
  task automatic post_done();
`ifdef AXUM_CTX_MOVER_IRQ_EN
    chk("intr_rise_with_done", intr, 1);
`else
    chk("intr_tied_low", intr, 0);
`endif
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("busy_back_idle", busy, 0);
`ifdef AXUM_CTX_MOVER_IRQ_EN
    chk("intr_holds", intr, 1);
`endif
    intr_clr = 1'b1;
    @(negedge clk);
    intr_clr = 1'b0;
    chk("intr_after_clr", intr, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    int          cyc, b0, nw, nr;
    bit          bok, found, dseen;
    logic        d;
    logic [1:0]  c, a;
    logic [31:0] rb;

    rst_n = 1'b0; start = 1'b0; dir = 1'b0; ctx = 2'd0; act = 2'd0; base = 32'h0; intr_clr = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_intr", intr, 0);
    chk("rst_req", bus.data_req_o, 0);
    chk("rst_we", bus.data_we_o, 0);
    chk("rst_be", bus.data_be_o, 0);
    chk("rst_addr", bus.data_addr_o, 0);
    chk("rst_wdata", bus.data_wdata_o, 0);
    rst_n = 1'b1;

    // Save ctx 2 over a zero-wait bus: latency and full address/data trace.
    gnt_delay = 0; rsp_delay = 0;
    b0 = log_addr.size();
    do_start(1'b0, 2'd2, 2'd0, 32'h1000);
    wait_done(cyc, bok);
    chk("save_latency", cyc, 125);
    chk("save_busy_held", bok, 1);
    chk("save_err", err, 0);
    check_xfer(b0, 1'b0, 2'd2, 32'h1000, 31);
    post_done();

    // Restore ctx 1 from an unaligned base with grants held off 3 cycles.
    gnt_delay = 3; rsp_delay = 0;
    b0 = log_addr.size();
    do_start(1'b1, 2'd1, 2'd0, 32'h2003);
    wait_done(cyc, bok);
    chk("restore_err", err, 0);
    check_xfer(b0, 1'b1, 2'd1, 32'h2003, 31);
    chk("restore_first_rd", log_addr[b0], 32'h2004);
    chk("restore_last_wr", log_addr[b0 + 61], 32'h200FC);
    post_done();

    // Moving the active context is refused without bus traffic.
    gnt_delay = 0;
    b0 = log_addr.size();
    do_start(1'b0, 2'd3, 2'd3, 32'h4000);
    wait_done(cyc, bok);
    chk("clash_latency", cyc, 1);
    chk("clash_err", err, 1);
    chk("clash_req", bus.data_req_o, 0);
    post_done();
    chk("clash_no_bus", log_addr.size() - b0, 0);

    // Error on the 5th write response aborts after exactly five writes.
    rb = $urandom & 32'h000F_FFFF;
    err_wr_at = wr_rsp_total + 5;
    b0 = log_addr.size();
    do_start(1'b0, 2'd0, 2'd1, rb);
    chk("err_cleared_on_start", err, 0);
    wait_done(cyc, bok);
    chk("buserr_err", err, 1);
    check_xfer(b0, 1'b0, 2'd0, rb, 5);
    nw = 0;
    for (int i = b0; i < log_we.size(); i++) if (log_we[i]) nw++;
    chk("buserr_writes", nw, 5);
    post_done();
    err_wr_at = -1;
    chk("err_sticky", err, 1);

    // Reset while the idx 10 write is waiting for its grant.
    gnt_delay = 2;
    b0 = log_addr.size();
    do_start(1'b0, 2'd1, 2'd2, 32'h3000);
    chk("err_cleared_by_good_start", err, 0);
    found = 0;
    for (int k = 0; k < 600 && !found; k++) begin
      @(negedge clk);
      #1;
      if (bus.data_req_o && bus.data_we_o && bus.data_addr_o == 32'h3028) found = 1;
    end
    chk("rst_target_reached", found, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_req", bus.data_req_o, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_addr", bus.data_addr_o, 0);
    dseen = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) dseen = 1;
    end
    chk("midrst_no_done", dseen, 0);
    rst_n = 1'b1;
    nr = 0;
    for (int i = b0; i < log_we.size(); i++) if (!log_we[i]) nr++;
    chk("midrst_reads_before", nr, 10);
    gnt_delay = 0;
    b0 = log_addr.size();
    do_start(1'b0, 2'd1, 2'd2, 32'h3000);
    wait_done(cyc, bok);
    chk("restart_latency", cyc, 125);
    chk("restart_first_rd", log_addr[b0], RF + 32'd128 + 32'd4);
    check_xfer(b0, 1'b0, 2'd1, 32'h3000, 31);
    post_done();

    // Randomized transfers with a stray start_i while busy.
    for (int t = 0; t < 3; t++) begin
      d = 1'($urandom_range(0, 1));
      a = 2'($urandom_range(0, 3));
      c = 2'(32'(a) + $urandom_range(1, 3));
      rb = $urandom & 32'h00FF_FFFF;
      gnt_delay = $urandom_range(0, 3);
      rsp_delay = $urandom_range(0, 2);
      b0 = log_addr.size();
      do_start(d, c, a, rb);
      repeat (10) @(negedge clk);
      dir = ~d; ctx = a; base = ~rb; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(cyc, bok);
      chk("rand_busy_held", bok, 1);
      chk("rand_err", err, 0);
      check_xfer(b0, d, c, rb, 31);
      post_done();
    end

    chk("req_fields_stable", stab_viol, 0);
    chk("stall_cycles_seen", stab_checks > 0, 1);
    chk("idle_bus_zero", zero_viol, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
